// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with PC, IF/ID register and an
// instruction-memory request/ready handshake.
// States: BOOT (one cycle after reset), FETCH (normal operation) and
// DRAIN (a redirect arrived while a request was still outstanding).
// Optional feature: define FETCH_PERF_CNT_EN to add the FetchCount and
// BubbleCount performance counter outputs.
module fetch_stage (
  input  logic        clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPC4,
  output logic        InstrValid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);

  // Opcode field all ones marks the bubble instruction.
  localparam logic [31:0] NOP = 32'hFC000000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] ipc_q;
  logic [31:0] ipc4_q;
  logic        vld_q;

  logic        redirect;
  logic [31:0] redir_pc;
  logic        hold;
  logic        capture;
  logic [31:0] pc_inc;

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are forced to word alignment.
  function automatic logic [31:0] align_word(input logic [31:0] tgt);
    return tgt & ~32'h0000_0003;
  endfunction

  // Decode redirect request and qualify a normal capture.
  always_comb begin
    redirect = 1'b0;
    redir_pc = '0;
    case (PCSrc)
      2'b01: begin
        redirect = BranchTaken;
        redir_pc = align_word(BranchTarget);
      end
      2'b10: begin
        redirect = 1'b1;
        redir_pc = align_word(JumpTarget);
      end
      default: begin
        redirect = 1'b0;
        redir_pc = '0;
      end
    endcase
    pc_inc  = next_seq(pc_q);
    hold    = Stall | ~PCWrite;
    capture = (state_q == FETCH) & ~redirect & ~Flush & ~hold & ImemReady;
  end

  // Fetch FSM: PC, request handshake and IF/ID register, all registered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      instr_q <= NOP;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (redirect) begin
            // Data arriving this cycle belongs to the wrong path.
            pc_q    <= redir_pc;
            instr_q <= NOP;
            vld_q   <= 1'b0;
            if (ImemReady) begin
              addr_q <= redir_pc;
            end else begin
              // Old request still pending: keep it on the bus until it completes.
              state_q <= DRAIN;
            end
          end else if (Flush) begin
            instr_q <= NOP;
            vld_q   <= 1'b0;
          end else if (capture) begin
            instr_q <= ImemData;
            ipc_q   <= pc_q;
            ipc4_q  <= pc_inc;
            vld_q   <= 1'b1;
            pc_q    <= pc_inc;
            addr_q  <= pc_inc;
          end
        end
        DRAIN: begin
          // Redirect/Flush still take effect, but DRAIN only ends on ImemReady.
          if (redirect) begin
            pc_q    <= redir_pc;
            instr_q <= NOP;
            vld_q   <= 1'b0;
          end else if (Flush) begin
            instr_q <= NOP;
            vld_q   <= 1'b0;
          end
          if (ImemReady) begin
            state_q <= FETCH;
            addr_q  <= redirect ? redir_pc : pc_q;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ImemReq    = req_q;
  assign ImemAddr   = addr_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign InstrPC4   = ipc4_q;
  assign InstrValid = vld_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count captured instructions and post-boot cycles with an empty IF/ID.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (capture) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q != BOOT) && !vld_q) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign FetchCount  = fetch_cnt_q;
  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, scoreboard-checked bench for fetch_stage.
// Each stimulus cycle pushes the outputs expected during that cycle; a
// monitor pops one entry per cycle and compares on the falling edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcwrite = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic        btaken = 1'b0;
  logic [31:0] btgt = '0;
  logic [31:0] jtgt = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  // Memory model: the word at address 4k holds k.
  assign imem_data = imem_addr >> 2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .Reset        (rst),
    .PCWrite      (pcwrite),
    .Stall        (stall),
    .Flush        (flush),
    .PCSrc        (pcsrc),
    .BranchTaken  (btaken),
    .BranchTarget (btgt),
    .JumpTarget   (jtgt),
    .ImemReq      (imem_req),
    .ImemAddr     (imem_addr),
    .ImemReady    (imem_ready),
    .ImemData     (imem_data),
    .Instr        (instr),
    .InstrPC      (instr_pc),
    .InstrPC4     (instr_pc4),
    .InstrValid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount   (fetch_count),
    .BubbleCount  (bubble_count)
`endif
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic        vld;
    logic        chkpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_no, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("ImemReq",    {31'b0, imem_req},    {31'b0, cur.req});
      check("ImemAddr",   imem_addr,            cur.addr);
      check("Instr",      instr,                cur.instr);
      check("InstrValid", {31'b0, instr_valid}, {31'b0, cur.vld});
      if (cur.chkpc) begin
        check("InstrPC",  instr_pc,  cur.ipc);
        check("InstrPC4", instr_pc4, cur.ipc4);
      end
      cyc_no++;
    end
  end

  // One clock cycle: drive inputs just after the rising edge and record the
  // outputs expected to be visible during this same cycle.
  task automatic cyc(input logic r, input logic pcw, input logic st, input logic fl,
                     input logic [1:0] src, input logic bt, input logic [31:0] tgt,
                     input logic rdy, input logic ereq, input logic [31:0] eaddr,
                     input logic [31:0] einstr, input logic [31:0] eipc,
                     input logic [31:0] eipc4, input logic evld, input logic echk);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    pcwrite    = pcw;
    stall      = st;
    flush      = fl;
    pcsrc      = src;
    btaken     = bt;
    btgt       = tgt;
    jtgt       = tgt;
    imem_ready = rdy;
    e.req   = ereq;
    e.addr  = eaddr;
    e.instr = einstr;
    e.ipc   = eipc;
    e.ipc4  = eipc4;
    e.vld   = evld;
    e.chkpc = echk;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   r pcw st fl src bt tgt           rdy | req addr          instr         ipc           ipc4          vld chk
    // Reset and sequential boot fetch
    cyc(1, 1, 0, 0, 2'd0, 0, 32'h0,        1,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h4,        32'h0,        32'h0,        32'h4,        1, 1);
    // Jump to 0x103 during a capture -> 0x100
    cyc(0, 1, 0, 0, 2'd2, 0, 32'h103,      1,  1, 32'h8,        32'h1,        32'h4,        32'h8,        1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h100,      NOP,          32'h0,        32'h0,        0, 0);
    // Branch not taken, then taken to 0x40
    cyc(0, 1, 0, 0, 2'd1, 0, 32'h40,       1,  1, 32'h104,      32'h40,       32'h100,      32'h104,      1, 1);
    cyc(0, 1, 0, 0, 2'd1, 1, 32'h40,       1,  1, 32'h108,      32'h41,       32'h104,      32'h108,      1, 1);
    // Delayed ready with a jump to 0x80 in the first wait cycle
    cyc(0, 1, 0, 0, 2'd2, 0, 32'h80,       0,  1, 32'h40,       NOP,          32'h0,        32'h0,        0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        0,  1, 32'h40,       NOP,          32'h0,        32'h0,        0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h40,       NOP,          32'h0,        32'h0,        0, 0);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h80,       NOP,          32'h0,        32'h0,        0, 0);
    cyc(0, 1, 0, 0, 2'd2, 0, 32'hC,        1,  1, 32'h84,       32'h20,       32'h80,       32'h84,       1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'hC,        NOP,          32'h0,        32'h0,        0, 0);
    // Stall two cycles at PC 0x10, then resume
    cyc(0, 1, 1, 0, 2'd0, 0, 32'h0,        1,  1, 32'h10,       32'h3,        32'hC,        32'h10,       1, 1);
    cyc(0, 1, 1, 0, 2'd0, 0, 32'h0,        1,  1, 32'h10,       32'h3,        32'hC,        32'h10,       1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h10,       32'h3,        32'hC,        32'h10,       1, 1);
    // PCWrite low holds, then Flush pulse
    cyc(0, 0, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h14,       32'h4,        32'h10,       32'h14,       1, 1);
    cyc(0, 1, 0, 1, 2'd0, 0, 32'h0,        1,  1, 32'h14,       32'h4,        32'h10,       32'h14,       1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h14,       NOP,          32'h10,       32'h14,       0, 1);
    // PC wrap at 0xFFFFFFFC (unaligned jump target is word-aligned)
    cyc(0, 1, 0, 0, 2'd2, 0, 32'hFFFFFFFF, 1,  1, 32'h18,       32'h5,        32'h14,       32'h18,       1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'hFFFFFFFC, NOP,          32'h0,        32'h0,        0, 0);
    // Enter DRAIN, flush in DRAIN, then reset in DRAIN
    cyc(0, 1, 0, 0, 2'd2, 0, 32'h200,      0,  1, 32'h0,        32'h3FFFFFFF, 32'hFFFFFFFC, 32'h0,        1, 1);
    cyc(0, 1, 0, 1, 2'd0, 0, 32'h0,        0,  1, 32'h0,        NOP,          32'h0,        32'h0,        0, 0);
    cyc(1, 1, 0, 0, 2'd0, 0, 32'h0,        0,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(1, 1, 0, 0, 2'd0, 0, 32'h0,        1,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  0, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    // First request after reset goes to 0; PCSrc=11 acts as sequential
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h0,        NOP,          32'h0,        32'h0,        0, 1);
    cyc(0, 1, 0, 0, 2'd3, 1, 32'h300,      1,  1, 32'h4,        32'h0,        32'h0,        32'h4,        1, 1);
    cyc(0, 1, 0, 0, 2'd0, 0, 32'h0,        1,  1, 32'h8,        32'h1,        32'h4,        32'h8,        1, 1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_scoreboard: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
